// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the two-stage pipeline hazard sequencer.
//   - FSM state encodings (RUN, LOAD_WAIT, FLUSH)
//   - M-stage control bits and the NOP constant that M captures on a bubble
package pipe_hazard_ctrl_pkg;

  localparam logic [1:0] ST_RUN       = 2'd0;
  localparam logic [1:0] ST_LOAD_WAIT = 2'd1;
  localparam logic [1:0] ST_FLUSH     = 2'd2;

  typedef struct packed {
    logic regwrite;
    logic load;
  } m_ctrl_t;

  localparam m_ctrl_t NOP_CTRL = '{regwrite: 1'b0, load: 1'b0};

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
// Ports:
//   clk    in  1  clock
//   reset  in  1  synchronous active-high clear
//   inc    in  1  count this cycle
//   q      out W  current count, sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard sequencer for the two-stage (X = decode/execute, M = memory/writeback)
// pipeline. Owns the M-stage scoreboard, drives the PC and X->M enables,
// inserts bubbles, squashes wrong-path instructions after a redirect and
// produces the operand-forward selects.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   valid_x .. redirect_x      description of the instruction currently in X
//   pc_wrt_en                  PC register write enable
//   xm_wrt_en                  X->M register enable (0 = M holds)
//   xm_bubble                  M captures a NOP
//   squash_x                   X instruction is wrong-path
//   fwd1, fwd2                 forward M writeback data to ALU operand 1 / 2
//   stall_cnt, flush_cnt       saturating performance counters
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_INDEX_BIT_WIDTH = 4,
  parameter int MEM_LAT             = 0,
  parameter int FLUSH_SLOTS         = 1,
  parameter int CNT_BITS            = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           valid_x,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] sr1_x,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] sr2_x,
  input  logic                           use1_x,
  input  logic                           use2_x,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] rd_x,
  input  logic                           regwrite_x,
  input  logic                           load_x,
  input  logic                           redirect_x,
  output logic                           pc_wrt_en,
  output logic                           xm_wrt_en,
  output logic                           xm_bubble,
  output logic                           squash_x,
  output logic                           fwd1,
  output logic                           fwd2,
  output logic [CNT_BITS-1:0]            stall_cnt,
  output logic [CNT_BITS-1:0]            flush_cnt
);

  localparam bit         LAT_EN   = (MEM_LAT > 0);
  localparam bit         FLUSH_EN = (FLUSH_SLOTS > 0);
  // The detecting RUN/FLUSH cycle is the first wait cycle, so LOAD_WAIT
  // lasts MEM_LAT-1 cycles and the pipeline stalls exactly MEM_LAT cycles.
  localparam logic [2:0] LAT_M1   = 3'((MEM_LAT > 0) ? MEM_LAT - 1 : 0);
  localparam logic [2:0] FSLOTS   = 3'(FLUSH_SLOTS);

  logic [1:0]                     state_q, state_d;
  logic                           m_valid_q, m_valid_d;
  logic [REG_INDEX_BIT_WIDTH-1:0] m_rd_q, m_rd_d;
  m_ctrl_t                        m_ctrl_q, m_ctrl_d;
  logic                           m_load_done_q, m_load_done_d;
  logic [2:0]                     wait_cnt_q, wait_cnt_d;
  logic [2:0]                     flush_left_q, flush_left_d;

  logic pc_en, xm_en, bubble, squash, load_pend, hit1, hit2;

  assign load_pend = m_valid_q & m_ctrl_q.load & ~m_load_done_q & LAT_EN;
  assign hit1 = use1_x & m_valid_q & m_ctrl_q.regwrite & (m_rd_q == sr1_x);
  assign hit2 = use2_x & m_valid_q & m_ctrl_q.regwrite & (m_rd_q == sr2_x);

  always_comb begin
    state_d       = state_q;
    m_valid_d     = m_valid_q;
    m_rd_d        = m_rd_q;
    m_ctrl_d      = m_ctrl_q;
    m_load_done_d = m_load_done_q;
    wait_cnt_d    = wait_cnt_q;
    flush_left_d  = flush_left_q;
    pc_en         = 1'b0;
    xm_en         = 1'b0;
    bubble        = 1'b0;
    squash        = 1'b0;

    case (state_q)
      ST_LOAD_WAIT: begin
        // wait_cnt counts the LOAD_WAIT cycles still to go, this one included.
        wait_cnt_d = wait_cnt_q - 3'd1;
        if (wait_cnt_q <= 3'd1) begin
          m_load_done_d = 1'b1;
          // A flush interrupted by the load resumes where it paused.
          state_d = (flush_left_q != 3'd0) ? ST_FLUSH : ST_RUN;
        end
      end
      default: begin
        if (load_pend) begin
          // Stall beats advance; a pending flush is paused, not counted.
          if (LAT_M1 == 3'd0) begin
            m_load_done_d = 1'b1;
          end else begin
            state_d    = ST_LOAD_WAIT;
            wait_cnt_d = LAT_M1;
          end
        end else begin
          pc_en         = 1'b1;
          xm_en         = 1'b1;
          squash        = (state_q == ST_FLUSH);
          bubble        = ~valid_x | squash;
          m_valid_d     = valid_x & ~squash;
          m_rd_d        = rd_x;
          m_load_done_d = 1'b0;
          if (bubble) begin
            m_ctrl_d = NOP_CTRL;
          end else begin
            m_ctrl_d.regwrite = regwrite_x;
            m_ctrl_d.load     = load_x;
          end
          if (state_q == ST_FLUSH) begin
            flush_left_d = flush_left_q - 3'd1;
            if (flush_left_q <= 3'd1) state_d = ST_RUN;
          end else if (redirect_x & valid_x & FLUSH_EN) begin
            state_d      = ST_FLUSH;
            flush_left_d = FSLOTS;
          end
        end
      end
    endcase
  end

  // Control state: cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      m_valid_q     <= 1'b0;
      m_ctrl_q      <= NOP_CTRL;
      m_load_done_q <= 1'b0;
      wait_cnt_q    <= 3'd0;
      flush_left_q  <= 3'd0;
    end else begin
      state_q       <= state_d;
      m_valid_q     <= m_valid_d;
      m_ctrl_q      <= m_ctrl_d;
      m_load_done_q <= m_load_done_d;
      wait_cnt_q    <= wait_cnt_d;
      flush_left_q  <= flush_left_d;
    end
  end

  // M destination index: qualified by m_valid_q, so it needs no reset
  always_ff @(posedge clk) begin
    m_rd_q <= m_rd_d;
  end

  assign pc_wrt_en = ~reset & pc_en;
  assign xm_wrt_en = ~reset & xm_en;
  assign xm_bubble = reset | bubble;
  assign squash_x  = reset | squash;
  assign fwd1      = ~reset & hit1;
  assign fwd2      = ~reset & hit2;

  sat_counter #(.W(CNT_BITS)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (~pc_wrt_en),
    .q     (stall_cnt)
  );

  sat_counter #(.W(CNT_BITS)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (squash_x & valid_x),
    .q     (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. dut_a: MEM_LAT=2, 16-bit counters.
// dut_b: MEM_LAT=1, 3-bit counters (to reach saturation quickly).
// Both take the same X-stage stimulus.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_x, use1_x, use2_x, regwrite_x, load_x, redirect_x;
  logic [3:0] sr1_x, sr2_x, rd_x;

  logic        a_pc, a_xm, a_bub, a_sq, a_f1, a_f2;
  logic [15:0] a_stall, a_flush;
  logic        b_pc, b_xm, b_bub, b_sq, b_f1, b_f2;
  logic [2:0]  b_stall, b_flush;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_INDEX_BIT_WIDTH(4), .MEM_LAT(2), .FLUSH_SLOTS(1), .CNT_BITS(16)) dut_a (
    .clk(clk), .reset(reset), .valid_x(valid_x), .sr1_x(sr1_x), .sr2_x(sr2_x),
    .use1_x(use1_x), .use2_x(use2_x), .rd_x(rd_x), .regwrite_x(regwrite_x),
    .load_x(load_x), .redirect_x(redirect_x), .pc_wrt_en(a_pc), .xm_wrt_en(a_xm),
    .xm_bubble(a_bub), .squash_x(a_sq), .fwd1(a_f1), .fwd2(a_f2),
    .stall_cnt(a_stall), .flush_cnt(a_flush)
  );

  pipe_hazard_ctrl #(.REG_INDEX_BIT_WIDTH(4), .MEM_LAT(1), .FLUSH_SLOTS(1), .CNT_BITS(3)) dut_b (
    .clk(clk), .reset(reset), .valid_x(valid_x), .sr1_x(sr1_x), .sr2_x(sr2_x),
    .use1_x(use1_x), .use2_x(use2_x), .rd_x(rd_x), .regwrite_x(regwrite_x),
    .load_x(load_x), .redirect_x(redirect_x), .pc_wrt_en(b_pc), .xm_wrt_en(b_xm),
    .xm_bubble(b_bub), .squash_x(b_sq), .fwd1(b_f1), .fwd2(b_f2),
    .stall_cnt(b_stall), .flush_cnt(b_flush)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                       input logic u1, input logic u2, input logic [3:0] rd,
                       input logic rw, input logic ld, input logic rdr);
    valid_x = v; sr1_x = s1; sr2_x = s2; use1_x = u1; use2_x = u2;
    rd_x = rd; regwrite_x = rw; load_x = ld; redirect_x = rdr;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Move to mid-cycle, where combinational outputs have settled.
  task automatic mid();
    #4;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle();

    // 1: reset held for 3 cycles, then release
    for (int i = 0; i < 3; i++) begin
      mid();
      check("rst_pc", 32'(a_pc), 32'd0);
      check("rst_squash", 32'(a_sq), 32'd1);
      if (i == 2) check("rst_bubble", 32'(a_bub), 32'd1);
      step();
    end
    reset = 1'b0;
    drive(1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    mid();
    check("run0_pc", 32'(a_pc), 32'd1);
    check("run0_mvalid", 32'(dut_a.m_valid_q), 32'd0);
    check("run0_fwd1", 32'(a_f1), 32'd0);
    check("run0_fwd2", 32'(a_f2), 32'd0);
    check("run0_state", 32'(dut_a.state_q), 32'(ST_RUN));
    step();

    // 2: back-to-back dependent ALU ops through r3
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
    mid();
    check("alu_w_pc", 32'(a_pc), 32'd1);
    step();
    drive(1'b1, 4'd3, 4'd7, 1'b1, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0);
    mid();
    check("alu_fwd1", 32'(a_f1), 32'd1);
    check("alu_fwd2", 32'(a_f2), 32'd0);
    check("alu_r_pc", 32'(a_pc), 32'd1);
    step();
    // Index matches r4 but the operand is unused: no forward
    drive(1'b1, 4'd4, 4'd4, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    mid();
    check("alu_nouse_fwd1", 32'(a_f1), 32'd0);
    check("alu_use_fwd2", 32'(a_f2), 32'd1);
    check("alu_stall_cnt", 32'(a_stall), 32'd0);
    step();

    // 3: MEM_LAT=2 load r5, consumer reads r5 on operand 2
    do_reset();
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0);
    mid();
    check("ld_issue_pc", 32'(a_pc), 32'd1);
    step();
    drive(1'b1, 4'd1, 4'd5, 1'b0, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0);
    mid();
    check("ld_stall1_pc", 32'(a_pc), 32'd0);
    check("ld_stall1_xm", 32'(a_xm), 32'd0);
    step();
    mid();
    check("ld_stall2_pc", 32'(a_pc), 32'd0);
    check("ld_wait_state", 32'(dut_a.state_q), 32'(ST_LOAD_WAIT));
    step();
    mid();
    check("ld_rel_pc", 32'(a_pc), 32'd1);
    check("ld_rel_fwd2", 32'(a_f2), 32'd1);
    check("ld_rel_fwd1", 32'(a_f1), 32'd0);
    check("ld_stall_cnt", 32'(a_stall), 32'd2);
    step();
    idle();
    mid();
    check("ld_after_pc", 32'(a_pc), 32'd1);
    check("ld_after_stall_cnt", 32'(a_stall), 32'd2);
    step();

    // 4: taken JAL (redirect + regwrite r1), one wrong-path slot
    do_reset();
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b1);
    mid();
    check("br_pc", 32'(a_pc), 32'd1);
    check("br_squash", 32'(a_sq), 32'd0);
    step();
    // Wrong-path instruction reading r1: forward still reflects the JAL link write
    drive(1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 4'd9, 1'b1, 1'b0, 1'b1);
    mid();
    check("fl_squash", 32'(a_sq), 32'd1);
    check("fl_bubble", 32'(a_bub), 32'd1);
    check("fl_pc", 32'(a_pc), 32'd1);
    check("fl_jal_fwd1", 32'(a_f1), 32'd1);
    step();
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0);
    mid();
    check("fl_ret_squash", 32'(a_sq), 32'd0);
    check("fl_ret_state", 32'(dut_a.state_q), 32'(ST_RUN));
    check("fl_ret_mvalid", 32'(dut_a.m_valid_q), 32'd0);
    check("fl_flush_cnt", 32'(a_flush), 32'd1);
    step();
    idle();
    mid();
    check("fl_next_mvalid", 32'(dut_a.m_valid_q), 32'd1);
    check("fl_flush_cnt_hold", 32'(a_flush), 32'd1);
    step();

    // 5: MEM_LAT=1 (dut_b), load in M while X holds a taken branch
    do_reset();
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0);
    mid();
    check("lb_issue_pc", 32'(b_pc), 32'd1);
    step();
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    mid();
    check("lb_stall_pc", 32'(b_pc), 32'd0);
    check("lb_stall_squash", 32'(b_sq), 32'd0);
    step();
    mid();
    check("lb_adv_pc", 32'(b_pc), 32'd1);
    check("lb_adv_squash", 32'(b_sq), 32'd0);
    step();
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0);
    mid();
    check("lb_fl_squash", 32'(b_sq), 32'd1);
    check("lb_fl_bubble", 32'(b_bub), 32'd1);
    step();
    mid();
    check("lb_ret_squash", 32'(b_sq), 32'd0);
    check("lb_stall_cnt", 32'(b_stall), 32'd1);
    check("lb_flush_cnt", 32'(b_flush), 32'd1);
    step();

    // 6: reset asserted in the middle of LOAD_WAIT (dut_a)
    do_reset();
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b1, 4'd5, 4'd0, 1'b1, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0);
    step();
    reset = 1'b1;
    mid();
    check("rlw_state_before", 32'(dut_a.state_q), 32'(ST_LOAD_WAIT));
    check("rlw_forced_pc", 32'(a_pc), 32'd0);
    check("rlw_forced_fwd1", 32'(a_f1), 32'd0);
    step();
    reset = 1'b0;
    idle();
    mid();
    check("rlw_state", 32'(dut_a.state_q), 32'(ST_RUN));
    check("rlw_mvalid", 32'(dut_a.m_valid_q), 32'd0);
    check("rlw_stall_cnt", 32'(a_stall), 32'd0);
    check("rlw_flush_cnt", 32'(a_flush), 32'd0);
    check("rlw_pc", 32'(a_pc), 32'd1);
    step();

    // 7: continuous loads; dut_b's 3-bit stall counter saturates
    do_reset();
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (i == 12) begin
        mid();
        check("sat_b_stall_pre", 32'(b_stall), 32'd6);
        step();
      end else begin
        step();
      end
    end
    mid();
    check("sat_b_stall", 32'(b_stall), 32'd7);
    check("sat_a_stall", 32'(a_stall), 32'd13);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
